// File: rtl/pipe_reg_pkg.sv
// ----------------------------------------------------------------------------
// pipe_reg_pkg
//   Shared definitions for the elastic pipeline register chain.
//   - PIPE_MAX_DEPTH : largest supported chain depth
//   - clog2()        : constant-evaluable ceil(log2) used for derived widths
//   - pipe_entry_t   : one slot's payload, sized by `PIPE_NB_CTRL/`PIPE_NB_DATA
// ----------------------------------------------------------------------------
`ifndef PIPE_NB_CTRL
`define PIPE_NB_CTRL 8
`endif
`ifndef PIPE_NB_DATA
`define PIPE_NB_DATA 96
`endif

package pipe_reg_pkg;

    localparam int unsigned PIPE_MAX_DEPTH = 8;

    typedef struct packed {
        logic [`PIPE_NB_CTRL-1:0] ctrl;
        logic [`PIPE_NB_DATA-1:0] data;
        logic                     halt;
        logic                     valid;
    } pipe_entry_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// ----------------------------------------------------------------------------
// pipe_stage_slot
//   One register slot of the elastic chain: holds, loads or flushes.
//   Reset > flush > advance > hold. Flush clears valid/ctrl but still captures
//   the source data and halt bit, matching the legacy per-stage registers.
// Ports
//   i_clk, i_reset      : clock (falling edge), synchronous active-high reset
//   i_adv               : slot advances this edge (includes step gating)
//   i_flush             : squash this slot this edge
//   i_src_*             : source entry (upstream slot or chain input)
//   o_valid/ctrl/data/halt : registered slot contents
// ----------------------------------------------------------------------------
module pipe_stage_slot
    import pipe_reg_pkg::*;
#(
    parameter int unsigned NB_CTRL = 8,
    parameter int unsigned NB_DATA = 96
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_adv,
    input  logic               i_flush,
    input  logic               i_src_valid,
    input  logic [NB_CTRL-1:0] i_src_ctrl,
    input  logic [NB_DATA-1:0] i_src_data,
    input  logic               i_src_halt,
    output logic               o_valid,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_halt
);

    logic               r_valid;
    logic [NB_CTRL-1:0] r_ctrl;
    logic [NB_DATA-1:0] r_data;
    logic               r_halt;

    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_halt  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= i_src_data;
            r_halt  <= i_src_halt;
        end else if (i_adv) begin
            r_valid <= i_src_valid;
            r_ctrl  <= i_src_valid ? i_src_ctrl : '0;
            r_data  <= i_src_data;
            r_halt  <= i_src_halt;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
    assign o_halt  = r_halt;

endmodule

// File: rtl/pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// pipe_stage_chain
//   Parametrised elastic pipeline register chain (DEPTH slots, falling-edge).
//   Each slot carries ctrl (bubbled on flush), data (captured on flush) and a
//   halt bit. Provides ready chain, occupancy count and a sticky halt flag.
//   Build option PIPE_SKID_EN: adds one skid slot after the last slot so that
//   o_ready no longer depends combinationally on i_ready.
// Ports
//   i_clk, i_reset   : clock (falling edge), synchronous active-high reset
//   i_step           : global advance enable; 0 freezes all slots
//   i_flush[DEPTH]   : per-slot flush
//   i_valid/o_ready  : upstream handshake; i_ctrl/i_data/i_halt payload
//   o_valid/i_ready  : downstream handshake; o_ctrl/o_data payload
//   o_halt           : sticky, set once the output slot has carried halt
//   o_count          : number of valid slots
// ----------------------------------------------------------------------------
module pipe_stage_chain
    import pipe_reg_pkg::*;
#(
    parameter int unsigned NB_CTRL = 8,
    parameter int unsigned NB_DATA = 96,
    parameter int unsigned DEPTH   = 2,
`ifdef PIPE_SKID_EN
    localparam int unsigned NB_CNT = clog2(DEPTH + 2)
`else
    localparam int unsigned NB_CNT = clog2(DEPTH + 1)
`endif
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic [DEPTH-1:0]   i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_halt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_halt,
    output logic [NB_CNT-1:0]  o_count
);

    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_halt;
    logic [NB_CTRL-1:0] w_ctrl     [DEPTH];
    logic [NB_DATA-1:0] w_data     [DEPTH];
    logic [DEPTH-1:0]   w_src_valid;
    logic [DEPTH-1:0]   w_src_halt;
    logic [NB_CTRL-1:0] w_src_ctrl [DEPTH];
    logic [NB_DATA-1:0] w_src_data [DEPTH];
    logic [DEPTH-1:0]   w_empty;
    logic [DEPTH-1:0]   w_adv;
    logic               w_tail_ready;
    logic               w_out_valid;
    logic               w_out_halt;
    logic [NB_CTRL-1:0] w_out_ctrl;
    logic [NB_DATA-1:0] w_out_data;
    logic               w_halt_cond;
    logic               r_last_flushed;
    logic               r_halt_sticky;

    // A flushed slot is treated as empty so upstream can move into it.
    assign w_empty = ~w_valid | i_flush;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            if (k == 0) begin : g_head
                assign w_src_valid[k] = i_valid;
                assign w_src_ctrl[k]  = i_ctrl;
                assign w_src_data[k]  = i_data;
                assign w_src_halt[k]  = i_halt;
            end else begin : g_body
                assign w_src_valid[k] = w_valid[k-1];
                assign w_src_ctrl[k]  = w_ctrl[k-1];
                assign w_src_data[k]  = w_data[k-1];
                assign w_src_halt[k]  = w_halt[k-1];
            end

            // adv_k = step & (empty_k | adv_{k+1}) unrolled: step & (any empty
            // slot from k to the tail, or the tail drains). Avoids a recursive vector.
            assign w_adv[k] = i_step & ((|w_empty[DEPTH-1:k]) | w_tail_ready);

            pipe_stage_slot #(
                .NB_CTRL (NB_CTRL),
                .NB_DATA (NB_DATA)
            ) u_slot (
                .i_clk       (i_clk),
                .i_reset     (i_reset),
                .i_adv       (w_adv[k]),
                .i_flush     (i_flush[k]),
                .i_src_valid (w_src_valid[k]),
                .i_src_ctrl  (w_src_ctrl[k]),
                .i_src_data  (w_src_data[k]),
                .i_src_halt  (w_src_halt[k]),
                .o_valid     (w_valid[k]),
                .o_ctrl      (w_ctrl[k]),
                .o_data      (w_data[k]),
                .o_halt      (w_halt[k])
            );
        end
    endgenerate

`ifdef PIPE_SKID_EN
    logic               r_skid_valid;
    logic [NB_CTRL-1:0] r_skid_ctrl;
    logic [NB_DATA-1:0] r_skid_data;
    logic               r_skid_halt;

    // Last slot may leave whenever the skid is empty: to downstream if it is
    // ready, otherwise into the skid. Keeps i_ready out of the o_ready path.
    assign w_tail_ready = ~r_skid_valid;

    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
            r_skid_halt  <= 1'b0;
        end else if (i_flush[DEPTH-1]) begin
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= w_data[DEPTH-1];
            r_skid_halt  <= w_halt[DEPTH-1];
        end else if (i_step) begin
            if (r_skid_valid) begin
                if (i_ready) begin
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                end
            end else if (w_valid[DEPTH-1] & ~i_ready) begin
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= w_ctrl[DEPTH-1];
                r_skid_data  <= w_data[DEPTH-1];
                r_skid_halt  <= w_halt[DEPTH-1];
            end
        end
    end

    assign w_out_valid = r_skid_valid | w_valid[DEPTH-1];
    assign w_out_ctrl  = r_skid_valid ? r_skid_ctrl : w_ctrl[DEPTH-1];
    assign w_out_data  = r_skid_valid ? r_skid_data : w_data[DEPTH-1];
    assign w_out_halt  = r_skid_valid ? r_skid_halt : w_halt[DEPTH-1];
    assign o_count     = NB_CNT'($countones({r_skid_valid, w_valid}));
`else
    assign w_tail_ready = i_ready;
    assign w_out_valid  = w_valid[DEPTH-1];
    assign w_out_ctrl   = w_ctrl[DEPTH-1];
    assign w_out_data   = w_data[DEPTH-1];
    assign w_out_halt   = w_halt[DEPTH-1];
    assign o_count      = NB_CNT'($countones(w_valid));
`endif

    // A flushed last slot keeps a captured halt visible until it reloads.
    assign w_halt_cond = w_out_halt & (w_out_valid | r_last_flushed);

    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            r_last_flushed <= 1'b0;
            r_halt_sticky  <= 1'b0;
        end else begin
            r_halt_sticky <= r_halt_sticky | w_halt_cond;
            if (i_flush[DEPTH-1]) begin
                r_last_flushed <= 1'b1;
            end else if (w_adv[DEPTH-1]) begin
                r_last_flushed <= 1'b0;
            end
        end
    end

    assign o_ready = w_adv[0];
    assign o_valid = w_out_valid;
    assign o_ctrl  = w_out_valid ? w_out_ctrl : '0;
    assign o_data  = w_out_data;
    assign o_halt  = r_halt_sticky | w_halt_cond;

endmodule
